mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose: shares one byte-wide RAM port and one IO register port among
// NUM_MASTERS bus masters. Master 0 is the debug/host master and can seize the
// bus with dbg_hold_in. Each owner keeps the bus for as long as it holds its
// request. Read data comes back one cycle after the access, together with a
// one-cycle m_rvalid pulse to the master that issued the read.
//
// Build option: define MEM_BUS_ARBITER_RR_EN for round-robin arbitration.
// With the macro undefined, arbitration is fixed priority and the lowest
// index wins.
//
// Ports:
//   clk_in, rst_n_in      clock (rising edge), asynchronous active-low reset
//   m_req/m_wr            per-master request and write (1) / read (0)
//   m_addr/m_dout         packed per-master byte address (32b) / write data (8b)
//   m_gnt                 registered one-hot ownership
//   m_ack                 combinational, access issued this cycle
//   m_rvalid/m_din        registered read-valid pulse / shared read data
//   dbg_hold_in           forces ownership to master 0
//   ram_*                 RAM enable, read/not-write, address, write/read data
//   io_*                  IO enable, register select, write, write/read data
//   io_full               IO output buffer full (stalls IO writes only)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [NUM_MASTERS-1:0]      m_req,
  input  logic [NUM_MASTERS-1:0]      m_wr,
  input  logic [32*NUM_MASTERS-1:0]   m_addr,
  input  logic [8*NUM_MASTERS-1:0]    m_dout,
  output logic [NUM_MASTERS-1:0]      m_gnt,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [NUM_MASTERS-1:0]      m_rvalid,
  output logic [7:0]                  m_din,
  input  logic                        dbg_hold_in,
  output logic                        ram_en,
  output logic                        ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_a,
  output logic [7:0]                  ram_d_out,
  input  logic [7:0]                  ram_d_in,
  output logic                        io_en,
  output logic [2:0]                  io_sel,
  output logic                        io_wr,
  output logic [7:0]                  io_d_out,
  input  logic [7:0]                  io_d_in,
  input  logic                        io_full
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  idx_t                    r_owner;
  idx_t                    w_owner_next;
  logic [NUM_MASTERS-1:0]  r_gnt;
  logic [NUM_MASTERS-1:0]  w_gnt_next;
  logic [NUM_MASTERS-1:0]  r_rvalid;
  logic                    r_rd_io;

  logic                    w_own_req;
  logic                    w_own_wr;
  logic [31:0]             w_own_addr;
  logic [7:0]              w_own_data;
  logic                    w_own_io;
  logic                    w_stall;
  logic                    w_issue;
  logic                    w_found;
  idx_t                    w_winner;
  logic                    w_unused_addr;

  // Request fields of the current owner.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_wr   = 1'b0;
    w_own_addr = '0;
    w_own_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_owner == idx_t'(i)) begin
        w_own_req  = m_req[i];
        w_own_wr   = m_wr[i];
        w_own_addr = m_addr[32*i +: 32];
        w_own_data = m_dout[8*i +: 8];
      end
    end
  end

  // The IO window is the top quarter of the address space just above the RAM.
  assign w_own_io      = (w_own_addr[RAM_ADDR_WIDTH -: 2] == 2'b11);
  // Only IO writes wait for buffer space; IO reads and RAM traffic never stall.
  assign w_stall       = w_own_io & w_own_wr & io_full;
  assign w_issue       = (r_state == ST_OWNED) & w_own_req & ~w_stall;
  assign w_unused_addr = ^w_own_addr;

`ifdef MEM_BUS_ARBITER_RR_EN
  idx_t r_ptr;

  // Round-robin: search requesters starting just after the last grantee.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!w_found && m_req[(int'(r_ptr) + k) % NUM_MASTERS]) begin
        w_found  = 1'b1;
        w_winner = idx_t'((int'(r_ptr) + k) % NUM_MASTERS);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ptr <= '0;
    end else if (w_state_next == ST_OWNED) begin
      r_ptr <= (w_owner_next == idx_t'(NUM_MASTERS - 1)) ? '0 : idx_t'(w_owner_next + 1'b1);
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!w_found && m_req[k]) begin
        w_found  = 1'b1;
        w_winner = idx_t'(k);
      end
    end
  end
`endif

  // Ownership: debug hold beats everything, then a requesting owner keeps the
  // bus, otherwise re-arbitrate in the same edge so there is no dead cycle.
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    if (dbg_hold_in) begin
      w_state_next = ST_OWNED;
      w_owner_next = '0;
    end else if ((r_state == ST_OWNED) && w_own_req) begin
      w_state_next = ST_OWNED;
      w_owner_next = r_owner;
    end else if (w_found) begin
      w_state_next = ST_OWNED;
      w_owner_next = w_winner;
    end else begin
      w_state_next = ST_IDLE;
      w_owner_next = '0;
    end
  end

  always_comb begin
    w_gnt_next = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_gnt_next[i] = (w_state_next == ST_OWNED) && (w_owner_next == idx_t'(i));
    end
  end

  // The rvalid one-hot is captured from the issuing owner, so a grant change
  // right after a read still returns data to the master that asked for it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rd_io  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_owner  <= w_owner_next;
      r_gnt    <= w_gnt_next;
      r_rvalid <= m_ack & {NUM_MASTERS{~w_own_wr}};
      if (w_issue && !w_own_wr) begin
        r_rd_io <= w_own_io;
      end
    end
  end

  assign m_gnt     = r_gnt;
  assign m_ack     = r_gnt & {NUM_MASTERS{w_issue}};
  assign m_rvalid  = r_rvalid;
  assign m_din     = r_rd_io ? io_d_in : ram_d_in;

  assign ram_en    = w_issue & ~w_own_io;
  assign ram_r_nw  = ~w_own_wr;
  assign ram_a     = w_own_addr[RAM_ADDR_WIDTH-1:0];
  assign ram_d_out = w_own_data;

  assign io_en     = w_issue & w_own_io;
  assign io_wr     = w_issue & w_own_io & w_own_wr;
  assign io_sel    = w_own_addr[2:0];
  assign io_d_out  = w_own_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Purpose: self-checking bench for mem_bus_arbiter (2 masters, 17-bit RAM).
// A driver applies one cycle of stimulus at a time and checks the cycle's bus
// outputs against a behavioural model of ownership; every read it expects to
// be issued is queued with its owner, return data and due cycle. A monitor
// pops that queue whenever m_rvalid is seen. Define MEM_BUS_ARBITER_RR_EN for
// both the DUT and this bench to exercise the round-robin build.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int N   = 2;
  localparam int RAW = 17;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic [N-1:0]     m_req, m_wr, m_gnt, m_ack, m_rvalid;
  logic [32*N-1:0]  m_addr;
  logic [8*N-1:0]   m_dout;
  logic [7:0]       m_din;
  logic             dbg_hold_in;
  logic             ram_en, ram_r_nw;
  logic [RAW-1:0]   ram_a;
  logic [7:0]       ram_d_out, ram_d_in;
  logic             io_en, io_wr;
  logic [2:0]       io_sel;
  logic [7:0]       io_d_out, io_d_in;
  logic             io_full;

  mem_bus_arbiter #(.NUM_MASTERS(N), .RAM_ADDR_WIDTH(RAW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_gnt(m_gnt), .m_ack(m_ack), .m_rvalid(m_rvalid), .m_din(m_din),
    .dbg_hold_in(dbg_hold_in),
    .ram_en(ram_en), .ram_r_nw(ram_r_nw), .ram_a(ram_a),
    .ram_d_out(ram_d_out), .ram_d_in(ram_d_in),
    .io_en(io_en), .io_sel(io_sel), .io_wr(io_wr),
    .io_d_out(io_d_out), .io_d_in(io_d_in), .io_full(io_full)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         owner;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       scoreQ[$];
  int         checks = 0;
  int         failures = 0;
  int         cycle = 0;
  int         mOwner = -1;
  int         mPtr = 0;
  logic [7:0] pendRam = 8'h00;
  logic [7:0] pendIo = 8'h00;

  always @(posedge clk_in) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h cycle=%0d", name, got, exp, cycle);
    end
  endtask

  function automatic bit isIo(input logic [31:0] a);
    return a[RAW -: 2] == 2'b11;
  endfunction

  function automatic logic [32*N-1:0] packAddr(input logic [31:0] a0, input logic [31:0] a1);
    return {a1, a0};
  endfunction

  // Pulls reset low, forgets every outstanding read, holds reset for the given
  // number of edges and releases it just after a rising edge.
  task automatic doReset(input int holdCycles);
    rst_n_in    = 1'b0;
    m_req       = '0;
    dbg_hold_in = 1'b0;
    io_full     = 1'b0;
    scoreQ.delete();
    mOwner = -1;
    mPtr   = 0;
    #1;
    checkOutput("rst_gnt",    32'(m_gnt),    32'd0);
    checkOutput("rst_rvalid", 32'(m_rvalid), 32'd0);
    checkOutput("rst_ack",    32'(m_ack),    32'd0);
    checkOutput("rst_ram_en", 32'(ram_en),   32'd0);
    checkOutput("rst_io_en",  32'(io_en),    32'd0);
    checkOutput("rst_io_wr",  32'(io_wr),    32'd0);
    repeat (holdCycles) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  // One bus cycle, entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] wr,
                               input logic [32*N-1:0] addr, input logic [8*N-1:0] dout,
                               input logic dbg, input logic full, input bit resetAfter);
    int          newOwner;
    bit          issue, io, stall;
    logic [31:0] a;
    logic [7:0]  d;
    logic        w;
    m_req       = req;
    m_wr        = wr;
    m_addr      = addr;
    m_dout      = dout;
    dbg_hold_in = dbg;
    io_full     = full;
    ram_d_in    = pendRam;
    io_d_in     = pendIo;
    pendRam     = 8'($urandom);
    pendIo      = 8'($urandom);
    issue = 0; io = 0; stall = 0; w = 1'b0; a = '0; d = '0;
    if (mOwner >= 0) begin
      a     = addr[mOwner*32 +: 32];
      d     = dout[mOwner*8 +: 8];
      w     = wr[mOwner];
      io    = isIo(a);
      stall = io && w && full;
      issue = req[mOwner] && !stall;
    end
    #3;
    checkOutput("gnt",    32'(m_gnt),  (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0);
    checkOutput("ack",    32'(m_ack),  issue ? (32'd1 << mOwner) : 32'd0);
    checkOutput("ram_en", 32'(ram_en), 32'(issue && !io));
    checkOutput("io_en",  32'(io_en),  32'(issue && io));
    checkOutput("io_wr",  32'(io_wr),  32'(issue && io && w));
    if (issue && !io) begin
      checkOutput("ram_a",     32'(ram_a),     32'(a[RAW-1:0]));
      checkOutput("ram_r_nw",  32'(ram_r_nw),  32'(!w));
      checkOutput("ram_d_out", 32'(ram_d_out), 32'(d));
    end
    if (issue && io) begin
      checkOutput("io_sel",   32'(io_sel),   32'(a[2:0]));
      checkOutput("io_d_out", 32'(io_d_out), 32'(d));
    end
    if (issue && !w) scoreQ.push_back('{mOwner, io ? pendIo : pendRam, cycle + 1});
    if (resetAfter) begin
      #2;
      doReset(2);
      return;
    end
    if (dbg) begin
      newOwner = 0;
    end else if (mOwner >= 0 && req[mOwner]) begin
      newOwner = mOwner;
    end else begin
      newOwner = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mPtr + k) % N;
        if (newOwner < 0 && req[i]) newOwner = i;
      end
    end
`ifdef MEM_BUS_ARBITER_RR_EN
    if (newOwner >= 0) mPtr = (newOwner + 1) % N;
`endif
    @(posedge clk_in);
    mOwner = newOwner;
    #1;
  endtask

  // Read-return monitor: every m_rvalid must match the oldest queued read.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_n_in) begin
      if (m_rvalid != '0) begin
        if (scoreQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rvalid got=0x%0h expected=0x0 cycle=%0d", m_rvalid, cycle);
        end else begin
          e = scoreQ.pop_front();
          checkOutput("rvalid_owner",   32'(m_rvalid), 32'd1 << e.owner);
          checkOutput("rdata",          32'(m_din),    32'(e.data));
          checkOutput("rvalid_latency", 32'(cycle),    32'(e.due));
        end
      end else if (scoreQ.size() != 0 && scoreQ[0].due <= cycle) begin
        checks++;
        failures++;
        $display("[TB] FAIL missing_rvalid got=0x0 expected=0x%0h cycle=%0d", 1 << scoreQ[0].owner, cycle);
        void'(scoreQ.pop_front());
      end
    end
  end

  initial begin
    logic [32*N-1:0] ra;
    logic [31:0]     a;
    m_req = '0; m_wr = '0; m_addr = '0; m_dout = '0;
    dbg_hold_in = 1'b0; io_full = 1'b0; ram_d_in = '0; io_d_in = '0;
    #1;
    doReset(2);

    // Master 1 RAM read of 0x10.
    applyStimulus(2'b10, 2'b00, packAddr(32'h0, 32'h10), 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("d_rd_gnt", 32'(m_gnt), 32'h2);
    applyStimulus(2'b10, 2'b00, packAddr(32'h0, 32'h10), 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, '0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Master 1 IO write of 0x41 held off by io_full for three cycles.
    applyStimulus(2'b10, 2'b10, packAddr(32'h0, 32'h30000), 16'h4100, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      applyStimulus(2'b10, 2'b10, packAddr(32'h0, 32'h30000), 16'h4100, 1'b0, 1'b1, 1'b0);
      checkOutput("d_stall_io_en", 32'(io_en), 32'd0);
    end
    applyStimulus(2'b10, 2'b10, packAddr(32'h0, 32'h30000), 16'h4100, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, '0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Both masters request; owners drop their request in turn.
    applyStimulus(2'b11, 2'b00, packAddr(32'h20, 32'h24), 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("d_arb_first", 32'(m_gnt), 32'h1);
    applyStimulus(2'b10, 2'b00, packAddr(32'h20, 32'h24), 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("d_arb_second", 32'(m_gnt), 32'h2);
    applyStimulus(2'b01, 2'b00, packAddr(32'h20, 32'h24), 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("d_arb_third", 32'(m_gnt), 32'h1);
    applyStimulus(2'b00, 2'b00, '0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Debug hold takes the bus from master 1 during its read.
    applyStimulus(2'b10, 2'b00, packAddr(32'h0, 32'h44), 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b10, 2'b00, packAddr(32'h0, 32'h44), 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("d_dbg_gnt", 32'(m_gnt), 32'h1);
    applyStimulus(2'b10, 2'b00, packAddr(32'h0, 32'h44), 16'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, '0, 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, '0, 16'h0, 1'b0, 1'b0, 1'b0);

    // IO read followed directly by a RAM read.
    applyStimulus(2'b01, 2'b00, packAddr(32'h30005, 32'h0), 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b00, packAddr(32'h30005, 32'h0), 16'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b01, 2'b00, packAddr(32'h00123, 32'h0), 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, '0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Reset between a read issue and its return.
    applyStimulus(2'b01, 2'b00, packAddr(32'h77, 32'h0), 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b00, packAddr(32'h77, 32'h0), 16'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b00, 2'b00, '0, 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, '0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    repeat (400) begin
      for (int m = 0; m < N; m++) begin
        a = $urandom;
        if ($urandom_range(0, 2) == 0) a[RAW -: 2] = 2'b11;
        else a[RAW -: 2] = 2'($urandom_range(0, 2));
        ra[32*m +: 32] = a;
      end
      applyStimulus(N'($urandom), N'($urandom), ra, 16'($urandom),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
                    $urandom_range(0, 149) == 0);
    end

    repeat (3) applyStimulus(2'b00, 2'b00, '0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("queue_drained", 32'(scoreQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
